// File: rtl/divider_iter.sv
// Iterative radix-2 restoring divider returning {remainder, quotient} as {HI, LO}.
// Optional build macro DIVIDER_EARLY_OUT_EN skips the iteration for trivial operands.
module divider_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           div_op,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic [2*WIDTH-1:0]   result,
   output logic                 done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_t;

   state_t            state_r;
   logic [CW-1:0]     counter_r;
   logic [WIDTH-1:0]  rem_r;
   logic [WIDTH-1:0]  quo_r;
   logic [WIDTH-1:0]  dvs_r;
   logic              quo_neg_r;
   logic              rem_neg_r;
   logic              div_zero_r;

   logic              is_signed_s;
   logic              accept_s;
   logic              early_s;
   logic [WIDTH-1:0]  abs_dvd_s;
   logic [WIDTH-1:0]  abs_dvs_s;
   logic [WIDTH:0]    rem_shift_s;
   logic [WIDTH:0]    rem_diff_s;
   logic              ge_s;
   logic [WIDTH-1:0]  rem_next_s;
   logic [WIDTH-1:0]  quo_fix_s;
   logic [WIDTH-1:0]  rem_fix_s;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   assign is_signed_s = (div_op == 2'b10);
   assign accept_s    = (state_r == ST_IDLE) && ((div_op == 2'b10) || (div_op == 2'b01));
   assign abs_dvd_s   = abs_val(dividend, is_signed_s);
   assign abs_dvs_s   = abs_val(divisor, is_signed_s);

`ifdef DIVIDER_EARLY_OUT_EN
   assign early_s = (abs_dvs_s == {WIDTH{1'b0}}) || (abs_dvd_s < abs_dvs_s);
`else
   assign early_s = 1'b0;
`endif

   // One restoring step: the extra top bit keeps the shifted remainder exact.
   always_comb begin
      rem_shift_s = {rem_r, quo_r[WIDTH-1]};
      rem_diff_s  = rem_shift_s - {1'b0, dvs_r};
      ge_s        = (rem_shift_s >= {1'b0, dvs_r});
      if (ge_s) begin
         rem_next_s = rem_diff_s[WIDTH-1:0];
      end else begin
         rem_next_s = rem_shift_s[WIDTH-1:0];
      end
   end

   // Sign correction; a zero divisor keeps the all-ones quotient untouched.
   always_comb begin
      if (quo_neg_r && !div_zero_r) begin
         quo_fix_s = {WIDTH{1'b0}} - quo_r;
      end else begin
         quo_fix_s = quo_r;
      end
      if (rem_neg_r) begin
         rem_fix_s = {WIDTH{1'b0}} - rem_r;
      end else begin
         rem_fix_s = rem_r;
      end
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         counter_r  <= {CW{1'b0}};
         rem_r      <= {WIDTH{1'b0}};
         quo_r      <= {WIDTH{1'b0}};
         dvs_r      <= {WIDTH{1'b0}};
         quo_neg_r  <= 1'b0;
         rem_neg_r  <= 1'b0;
         div_zero_r <= 1'b0;
         result     <= {(2*WIDTH){1'b0}};
         done       <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  dvs_r      <= abs_dvs_s;
                  quo_neg_r  <= is_signed_s && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  rem_neg_r  <= is_signed_s && dividend[WIDTH-1];
                  div_zero_r <= (abs_dvs_s == {WIDTH{1'b0}});
                  counter_r  <= {CW{1'b0}};
                  done       <= 1'b0;
                  if (early_s) begin
                     rem_r   <= abs_dvd_s;
                     quo_r   <= (abs_dvs_s == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                     state_r <= ST_FIX;
                  end else begin
                     rem_r   <= {WIDTH{1'b0}};
                     quo_r   <= abs_dvd_s;
                     state_r <= ST_CALC;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_CALC: begin
               rem_r     <= rem_next_s;
               quo_r     <= {quo_r[WIDTH-2:0], ge_s};
               counter_r <= counter_r + {{(CW-1){1'b0}}, 1'b1};
               if (counter_r == CW'(WIDTH - 1)) begin
                  state_r <= ST_FIX;
               end else begin
                  state_r <= ST_CALC;
               end
            end
            ST_FIX: begin
               result  <= {rem_fix_s, quo_fix_s};
               done    <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               done    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: behavioural reference model, directed
// corner cases and randomized operations, compared every cycle.
module tb_divider_iter;

   logic        clk;
   logic        rst;
   logic [1:0]  div_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [63:0] result;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: cycles still busy, expected outputs, pending result.
   int          m_busy   = 0;
   logic        m_done   = 1'b1;
   logic [63:0] m_result = 64'h0;
   logic [63:0] m_pend   = 64'h0;

   divider_iter #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .div_op   (div_op),
      .dividend (dividend),
      .divisor  (divisor),
      .result   (result),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish (got running, need finished)");
      $fatal(1, "timeout");
   end

   function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'h0) return {a, 32'hFFFFFFFF};
      if (op == 2'b01) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIVIDER_EARLY_OUT_EN
      longint aa, ab;
      if (op == 2'b10) begin
         aa = longint'($signed(a));
         ab = longint'($signed(b));
         if (aa < 0) aa = -aa;
         if (ab < 0) ab = -ab;
      end else begin
         aa = longint'({32'h0, a});
         ab = longint'({32'h0, b});
      end
      if (ab == 0 || aa < ab) return 1;
      return 33;
`else
      return 33;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: update the model from the inputs seen at the edge, then compare.
   task automatic step();
      @(posedge clk);
      if (!rst) begin
         m_busy   = 0;
         m_done   = 1'b1;
         m_result = 64'h0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            m_done   = 1'b1;
            m_result = m_pend;
         end
      end else if (div_op == 2'b01 || div_op == 2'b10) begin
         m_pend = ref_div(div_op, dividend, divisor);
         m_busy = exp_lat(div_op, dividend, divisor);
         m_done = 1'b0;
      end
      @(negedge clk);
      chk("cycle done", {63'h0, done}, {63'h0, m_done});
      chk("cycle result", result, m_result);
   endtask

   // Issue one request and measure how long done stays low.
   task automatic run_div(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int inject);
      int low;
      div_op = op; dividend = a; divisor = b;
      step();
      div_op = 2'b00; dividend = $urandom; divisor = $urandom;
      low = 0;
      while (done === 1'b0 && low < 40) begin
         low++;
         if (low == inject) begin
            div_op = 2'b10; dividend = 32'h00000064; divisor = 32'h00000003;
         end
         step();
         div_op = 2'b00;
      end
      chk({name, " latency"}, 64'(low), 64'(exp_lat(op, a, b)));
      chk({name, " result"}, result, exp);
   endtask

   initial begin
      logic [31:0] a, b;
      logic [1:0]  op;
      int          sel;
      rst = 1'b0; div_op = 2'b00; dividend = 32'h0; divisor = 32'h0;
      step();
      step();
      chk("reset done", {63'h0, done}, 64'h1);
      chk("reset result", result, 64'h0);
      rst = 1'b1;
      step();

      chk("model u100/7", ref_div(2'b01, 32'd100, 32'd7), 64'h00000002_0000000E);
      chk("model s-7/2", ref_div(2'b10, 32'hFFFFFFF9, 32'h2), 64'hFFFFFFFF_FFFFFFFD);
      chk("model s7/-2", ref_div(2'b10, 32'h7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
      chk("model ovf", ref_div(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

      run_div("u100/7", 2'b01, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
      run_div("s-7/2", 2'b10, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 0);
      run_div("s7/-2", 2'b10, 32'h7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0);
      run_div("u/0", 2'b01, 32'h12345678, 32'h0, 64'h12345678_FFFFFFFF, 0);
      run_div("s/0", 2'b10, 32'h12345678, 32'h0, 64'h12345678_FFFFFFFF, 0);
      run_div("s-/0", 2'b10, 32'h87654321, 32'h0, 64'h87654321_FFFFFFFF, 0);
      run_div("s ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
      run_div("u max/1", 2'b01, 32'hFFFFFFFF, 32'h1, 64'h00000000_FFFFFFFF, 0);
      run_div("u 3/5", 2'b01, 32'd3, 32'd5, 64'h00000003_00000000, 0);
      run_div("s -3/5", 2'b10, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFD_00000000, 0);

      // Request while busy must be ignored; result must then stay put.
      run_div("busy req", 2'b01, 32'd1000, 32'd9, 64'h00000001_0000006F, 10);
      for (int i = 0; i < 5; i++) step();
      chk("busy hold", result, 64'h00000001_0000006F);

      // Reset in the middle of a divide discards it.
      div_op = 2'b01; dividend = 32'd500; divisor = 32'd7;
      step();
      div_op = 2'b00;
      for (int i = 0; i < 14; i++) step();
      rst = 1'b0;
      step();
      chk("midrst done", {63'h0, done}, 64'h1);
      chk("midrst result", result, 64'h0);
      rst = 1'b1;
      step();
      run_div("post rst", 2'b01, 32'd100, 32'd7, 64'h00000002_0000000E, 0);

      // Randomized operations with idle gaps and reserved op codes.
      for (int n = 0; n < 200; n++) begin
         op  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         a   = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: b = 32'h0;
            1: b = $urandom_range(1, 15);
            2: b = 32'hFFFFFFFF;
            3: begin a = $urandom_range(0, 100); b = $urandom; end
            4: begin a = 32'h80000000; b = $urandom; end
            default: b = $urandom;
         endcase
         run_div("rand", op, a, b, ref_div(op, a, b), $urandom_range(0, 40));
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            div_op = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00;
            step();
            div_op = 2'b00;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
